// File: rtl/vlogic_pipe_if.sv
// vlogic_pipe_if: request/result bus of the vector bitwise-logic pipe.
interface vlogic_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_WIDTH-1:0]   in_addr;
  logic [DATA_WIDTH-1:0]   in_vec0;
  logic [DATA_WIDTH-1:0]   in_vec1;
  logic [DATA_WIDTH-1:0]   in_vec_old;
  logic [DATA_WIDTH/8-1:0] in_be;
  logic [2:0]              in_opSel;
  logic [DATA_WIDTH-1:0]   out_vec;
  logic [ADDR_WIDTH-1:0]   out_addr;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic [CNT_WIDTH-1:0]    occupancy;
  modport master (
    output in_valid, in_addr, in_vec0, in_vec1, in_vec_old, in_be, in_opSel, out_ready,
    input  in_ready, out_vec, out_addr, out_valid, busy, occupancy
  );
  modport slave (
    input  in_valid, in_addr, in_vec0, in_vec1, in_vec_old, in_be, in_opSel, out_ready,
    output in_ready, out_vec, out_addr, out_valid, busy, occupancy
  );
endinterface

// File: rtl/vlogic_pipe.sv
// vlogic_pipe: RVV bitwise-logic unit with byte-masked merge, LATENCY-deep lockstep pipeline and output backpressure.
module vlogic_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 3,
  parameter int LATENCY     = 6,
  parameter int CNT_WIDTH   = 4
) (
  input logic         clk,
  input logic         rst_n,
  vlogic_pipe_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  logic                   adv, acc, drain;
  logic [OPSEL_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0]  a, b, f, merged;
  logic [DATA_WIDTH-1:0]  data_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [LATENCY-1:0]     vld_q;
  logic [DATA_WIDTH-1:0]  data_q [LATENCY];
  logic [ADDR_WIDTH-1:0]  addr_q [LATENCY];
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  assign op    = bus.in_opSel;
  assign a     = bus.in_vec0;
  assign b     = bus.in_vec1;
  assign adv   = !vld_q[LATENCY-1] | bus.out_ready;
  assign acc   = bus.in_valid & adv;
  assign drain = vld_q[LATENCY-1] & bus.out_ready;
  always_comb begin
    f = op == 3'd1 ? a & b    :
        op == 3'd2 ? a | b    :
        op == 3'd3 ? a ^ b    :
        op == 3'd4 ? a & ~b   :
        op == 3'd5 ? ~(a & b) :
        op == 3'd6 ? ~(a | b) :
        op == 3'd7 ? ~(a ^ b) : '0;
    merged = bus.in_vec_old;
    for (int i = 0; i < NB; i++)
      if (bus.in_be[i]) merged[8*i +: 8] = f[8*i +: 8];
  end
  // Empty slots carry zeros so the output is clean whenever out_valid is low
  assign data_d = acc ? merged : '0;
  assign addr_d = acc ? bus.in_addr : '0;
  assign cnt_d  = cnt_q + CNT_WIDTH'(acc) - CNT_WIDTH'(drain);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[0]  <= 1'b0;
      data_q[0] <= '0;
      addr_q[0] <= '0;
    end else if (adv) begin
      vld_q[0]  <= acc;
      data_q[0] <= data_d;
      addr_q[0] <= addr_d;
    end
  end
  for (genvar s = 1; s < LATENCY; s++) begin : g_stg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[s]  <= 1'b0;
        data_q[s] <= '0;
        addr_q[s] <= '0;
      end else if (adv) begin
        vld_q[s]  <= vld_q[s-1];
        data_q[s] <= data_q[s-1];
        addr_q[s] <= addr_q[s-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[LATENCY-1];
  assign bus.out_vec   = data_q[LATENCY-1];
  assign bus.out_addr  = addr_q[LATENCY-1];
  assign bus.occupancy = cnt_q;
  assign bus.busy      = cnt_q != '0;
endmodule

// File: tb/tb_vlogic_pipe.sv
// tb_vlogic_pipe: directed and randomized checks of vlogic_pipe against a beat-queue reference model.
module tb_vlogic_pipe;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int L  = 6;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vlogic_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  vlogic_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus1 ();

  vlogic_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(3), .LATENCY(L), .CNT_WIDTH(CW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  vlogic_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(3), .LATENCY(1), .CNT_WIDTH(CW))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] vec;
    int            age;
  } beat_t;

  beat_t         q[$];
  logic [63:0]   dq[$];
  int            n_assert = 0;
  int            n_fail = 0;
  logic          last_acc, last_drain;
  logic [AW-1:0] last_drain_addr;

  function automatic logic [DW-1:0] ref_op(logic [DW-1:0] a, logic [DW-1:0] b,
                                           logic [DW-1:0] old, logic [DW/8-1:0] be, logic [2:0] op);
    logic [DW-1:0] r;
    case (op)
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a & ~b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      3'd7: r = ~(a ^ b);
      default: r = '0;
    endcase
    for (int i = 0; i < DW/8; i++) if (!be[i]) r[8*i +: 8] = old[8*i +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [AW-1:0] addr, logic [DW-1:0] a, logic [DW-1:0] b,
                       logic [DW-1:0] old, logic [7:0] be, logic [2:0] op);
    bus.in_valid = v; bus.in_addr = addr; bus.in_vec0 = a; bus.in_vec1 = b;
    bus.in_vec_old = old; bus.in_be = be; bus.in_opSel = op;
  endtask

  // One clock: check handshake-side signals before the edge, advance the model, check outputs after it
  task automatic tick();
    logic exp_ov, adv;
    #1;
    exp_ov = q.size() > 0 && q[0].age == L-1;
    adv = !exp_ov || bus.out_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(adv));
    last_acc = bus.in_valid && adv;
    last_drain = bus.out_valid && bus.out_ready;
    last_drain_addr = bus.out_addr;
    if (last_drain && dq.size() > 0) chk("directed_vec", bus.out_vec, dq.pop_front());
    @(posedge clk);
    if (adv) begin
      if (exp_ov) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (last_acc) q.push_back('{addr: bus.in_addr, age: 0,
        vec: ref_op(bus.in_vec0, bus.in_vec1, bus.in_vec_old, bus.in_be, bus.in_opSel)});
    end
    #1;
    exp_ov = q.size() > 0 && q[0].age == L-1;
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("out_vec", bus.out_vec, exp_ov ? q[0].vec : 64'd0);
    chk("out_addr", 64'(bus.out_addr), exp_ov ? 64'(q[0].addr) : 64'd0);
    chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
    chk("busy", 64'(bus.busy), 64'(q.size() != 0));
  endtask

  initial begin
    logic [63:0] a, b;
    int k, nexp, peak, cyc, stall_left, n;
    logic stalled;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_addr = '0; bus1.in_vec0 = '0; bus1.in_vec1 = '0;
    bus1.in_vec_old = '0; bus1.in_be = '0; bus1.in_opSel = '0; bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_vec", bus.out_vec, 0);
    chk("rst_occupancy", 64'(bus.occupancy), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ops back to back
    a = 64'hF0F0_F0F0_F0F0_F0F0; b = 64'hFF00_FF00_FF00_FF00;
    dq = '{64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0, 64'h0FF0_0FF0_0FF0_0FF0,
           64'h00F0_00F0_00F0_00F0, 64'h0FFF_0FFF_0FFF_0FFF, 64'h000F_000F_000F_000F,
           64'hF00F_F00F_F00F_F00F};
    for (int op = 1; op <= 7; op++) begin
      drive(1, AW'(op), a, b, 64'h0, 8'hFF, 3'(op));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick();
    chk("basic_all_seen", 64'(dq.size()), 0);

    // Mask merge
    dq = '{64'h1122_3344_FFFF_FFFF, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788};
    drive(1, 32'h100, '1, 0, 64'h1122_3344_5566_7788, 8'h0F, 3'd3); tick();
    drive(1, 32'h101, '1, 0, 64'h1122_3344_5566_7788, 8'h00, 3'd3); tick();
    drive(1, 32'h102, '1, '1, 64'h1122_3344_5566_7788, 8'h00, 3'd0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick();
    chk("mask_all_seen", 64'(dq.size()), 0);

    // Backpressure: 3-cycle stall as soon as the first result appears
    k = 0; nexp = 0; peak = 0; cyc = 0; stall_left = 0; stalled = 1'b0;
    while ((k < 8 || q.size() > 0) && cyc < 200) begin
      if (k < 8) drive(1, AW'(k), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                       {$urandom(), $urandom()}, 8'($urandom()), 3'($urandom()));
      else bus.in_valid = 1'b0;
      bus.out_ready = !(stall_left > 0);
      tick();
      if (last_acc) k++;
      if (last_drain) begin chk("bp_order", 64'(last_drain_addr), 64'(nexp)); nexp++; end
      if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
      if (!stalled && bus.out_valid) begin stall_left = 3; stalled = 1'b1; end
      else if (stall_left > 0) stall_left--;
      cyc++;
    end
    chk("bp_timeout", 64'(cyc < 200), 1);
    chk("bp_count", 64'(nexp), 8);
    chk("bp_peak", 64'(peak), 6);
    bus.out_ready = 1'b1;

    // Steady stream, then drain
    for (int i = 0; i < 20; i++) begin
      drive(1, AW'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()},
            {$urandom(), $urandom()}, 8'($urandom()), 3'($urandom()));
      tick();
    end
    chk("steady_occ", 64'(bus.occupancy), 6);
    chk("steady_busy", 64'(bus.busy), 1);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin tick(); n++; end
    chk("drain_len", 64'(n), 6);

    // Randomized valid/ready with a source that holds refused beats
    bus.in_valid = 1'b0; last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || last_acc)
        drive(1'($urandom_range(0, 2) != 0), AW'($urandom()), {$urandom(), $urandom()},
              {$urandom(), $urandom()}, {$urandom(), $urandom()}, 8'($urandom()), 3'($urandom()));
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin tick(); n++; end
    chk("rand_drained", 64'(q.size()), 0);

    // Asynchronous reset with beats in flight
    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(i + 40), {$urandom(), $urandom()}, '1, 0, 8'hFF, 3'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 0);
    chk("arst_out_vec", bus.out_vec, 0);
    chk("arst_out_addr", 64'(bus.out_addr), 0);
    chk("arst_occupancy", 64'(bus.occupancy), 0);
    chk("arst_busy", 64'(bus.busy), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();

    // LATENCY=1 build
    bus1.in_valid = 1'b1; bus1.in_addr = 32'd5; bus1.in_vec0 = 64'hFF; bus1.in_vec1 = 64'h0F;
    bus1.in_be = 8'hFF; bus1.in_opSel = 3'd1; bus1.out_ready = 1'b1;
    #1 chk("l1_in_ready", 64'(bus1.in_ready), 1);
    @(posedge clk); #1;
    chk("l1_out_valid", 64'(bus1.out_valid), 1);
    chk("l1_out_vec", bus1.out_vec, 64'h0F);
    chk("l1_out_addr", 64'(bus1.out_addr), 5);
    bus1.out_ready = 1'b0; bus1.in_addr = 32'd6;
    #1 chk("l1_hold_ready", 64'(bus1.in_ready), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("l1_hold_valid", 64'(bus1.out_valid), 1);
      chk("l1_hold_vec", bus1.out_vec, 64'h0F);
      chk("l1_hold_addr", 64'(bus1.out_addr), 5);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("l1_next_addr", 64'(bus1.out_addr), 6);
    chk("l1_next_vec", bus1.out_vec, 64'h0F);
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("l1_idle_valid", 64'(bus1.out_valid), 0);
    chk("l1_idle_vec", bus1.out_vec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
